// File: rtl/fairy_sram_responder.sv
// fairy_sram_responder: word RAM behind one core SRAM port.
// Programmable ack wait states and a fixed-latency read data pipe.
module fairy_sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int ACK_WAIT = 0,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sram_cen,
  input  logic        sram_wr,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic        sram_ack,
  output logic        sram_rrdy,
  output logic [31:0] sram_rdata,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT =
    4'((ACK_WAIT > 0) ? ACK_WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [3:0]         cen_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  widx_q;
  logic [31:0]        wdata_q;

  logic [31:0]        ram [DEPTH];
  logic [31:0]        rd_word;
  logic               req;
  logic               do_wr;
  logic               do_rd;

  logic               vld [READ_LAT];
  logic [31:0]        dat [READ_LAT];

  logic               unused_addr;

  assign req   = (sram_cen != 4'b1111);
  assign do_wr = (state == S_ACK) && wr_q;
  assign do_rd = (state == S_ACK) && !wr_q;

  assign unused_addr =
    ^{sram_addr[31:ADDR_W+2], sram_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cen_q    <= 4'b1111;
      wr_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      sram_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sram_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            cen_q   <= sram_cen;
            wr_q    <= sram_wr;
            widx_q  <= sram_addr[ADDR_W+1:2];
            wdata_q <= sram_wdata;
            busy    <= 1'b1;
            if (ACK_WAIT > 0) begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state    <= S_ACK;
              sram_ack <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state    <= S_ACK;
            sram_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!cen_q[i])
          ram[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rd_word = ram[widx_q];

  // Data only advances with its valid bit, so the last stage
  // holds the most recent read between rrdy pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= do_rd;
      if (do_rd)
        dat[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1])
          dat[i] <= dat[i-1];
      end
    end
  end

  assign sram_rrdy  = vld[READ_LAT-1];
  assign sram_rdata = dat[READ_LAT-1];

endmodule

// File: tb/tb_fairy_sram_responder.sv
// tb_fairy_sram_responder: two responders (no-wait and waited/long-latency)
// driven by directed and random requests against a transaction-level model.
module tb_fairy_sram_responder;

  localparam int AW_A = 0;
  localparam int RL_A = 1;
  localparam int AW_B = 3;
  localparam int RL_B = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  cen_a = 4'hF;
  logic        wr_a = 1'b0;
  logic [31:0] addr_a = '0;
  logic [31:0] wdata_a = '0;
  logic        ack_a, rrdy_a, busy_a;
  logic [31:0] rdata_a;

  logic [3:0]  cen_b = 4'hF;
  logic        wr_b = 1'b0;
  logic [31:0] addr_b = '0;
  logic [31:0] wdata_b = '0;
  logic        ack_b, rrdy_b, busy_b;
  logic [31:0] rdata_b;

  int cyc = 0;
  int checks = 0;
  int errs = 0;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rd_t;

  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  fairy_sram_responder #(
    .ADDR_W(10), .ACK_WAIT(AW_A), .READ_LAT(RL_A)
  ) dut_a (
    .clk(clk), .reset(reset),
    .sram_cen(cen_a), .sram_wr(wr_a),
    .sram_addr(addr_a), .sram_wdata(wdata_a),
    .sram_ack(ack_a), .sram_rrdy(rrdy_a),
    .sram_rdata(rdata_a), .busy(busy_a)
  );

  fairy_sram_responder #(
    .ADDR_W(10), .ACK_WAIT(AW_B), .READ_LAT(RL_B)
  ) dut_b (
    .clk(clk), .reset(reset),
    .sram_cen(cen_b), .sram_wr(wr_b),
    .sram_addr(addr_b), .sram_wdata(wdata_b),
    .sram_ack(ack_b), .sram_rrdy(rrdy_b),
    .sram_rdata(rdata_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input bit s);
    return s ? ack_b : ack_a;
  endfunction

  function automatic logic busy_of(input bit s);
    return s ? busy_b : busy_a;
  endfunction

  task automatic drive(input bit s, input logic [3:0] c,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (s) begin
      cen_b = c; wr_b = w; addr_b = a; wdata_b = d;
    end else begin
      cen_a = c; wr_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // Read-data expectation: a read acked in cycle N shows up in
  // cycle N+READ_LAT; otherwise rdata keeps the previous value.
  task automatic mon(input bit s);
    logic        r;
    logic [31:0] d;
    logic        e;
    logic [31:0] ed;
    if (reset) return;
    r = s ? rrdy_b : rrdy_a;
    d = s ? rdata_b : rdata_a;
    e = 1'b0;
    if (s) begin
      if (qb.size() != 0 && qb[0].cyc == cyc) begin
        e = 1'b1; last_b = qb[0].d; void'(qb.pop_front());
      end
      ed = last_b;
    end else begin
      if (qa.size() != 0 && qa[0].cyc == cyc) begin
        e = 1'b1; last_a = qa[0].d; void'(qa.pop_front());
      end
      ed = last_a;
    end
    chk(s ? "rrdy_b" : "rrdy_a", {31'd0, r}, {31'd0, e});
    chk(s ? "rdata_b" : "rdata_a", d, ed);
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  task automatic xact(input bit s, input logic [3:0] c,
                      input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int          aw, k0, ea;
    logic [3:0]  idx;
    logic [31:0] word;
    rd_t         e;
    aw = s ? AW_B : AW_A;
    @(posedge clk); #1;
    chk("idle_ack", {31'd0, ack_of(s)}, 32'd0);
    chk("idle_busy", {31'd0, busy_of(s)}, 32'd0);
    drive(s, c, w, a, d);
    k0 = cyc;
    ea = k0 + 1 + aw;
    while (cyc < ea) begin
      @(posedge clk); #1;
      if (cyc < ea)
        drive(s, c, 1'($urandom), $urandom, $urandom);
      chk("busy", {31'd0, busy_of(s)}, 32'd1);
      chk("ack", {31'd0, ack_of(s)}, {31'd0, cyc == ea});
    end
    drive(s, 4'hF, 1'b0, '0, '0);
    idx  = a[5:2];
    word = s ? mem_b[idx] : mem_a[idx];
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (!c[i]) word[8*i +: 8] = d[8*i +: 8];
      if (s) mem_b[idx] = word;
      else   mem_a[idx] = word;
    end else begin
      e.cyc = ea + (s ? RL_B : RL_A);
      e.d   = word;
      if (s) qb.push_back(e);
      else   qa.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'hF, 1'b0, '0, '0);
      drive(1'b1, 4'hF, 1'b0, '0, '0);
      chk("noreq_ack_a", {31'd0, ack_a}, 32'd0);
      chk("noreq_ack_b", {31'd0, ack_b}, 32'd0);
      chk("noreq_busy_a", {31'd0, busy_a}, 32'd0);
      chk("noreq_busy_b", {31'd0, busy_b}, 32'd0);
    end
  endtask

  task automatic rst_check();
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_rrdy_a", {31'd0, rrdy_a}, 32'd0);
    chk("rst_rrdy_b", {31'd0, rrdy_b}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    #1;
    rst_check();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          k0;

    #2;
    rst_check();
    @(posedge clk); #1;
    reset = 1'b0;

    // known contents for the 16 words the test touches
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        if (i == 12) v = 32'h0;
        if (i == 8)  v = 32'h1122_3344;
        xact(1'(s), 4'b0000, 1'b1, 32'(i) << 2, v);
      end
    end

    // basic write then read
    xact(1'b0, 4'b0000, 1'b1, 32'h10, 32'hDEAD_BEEF);
    xact(1'b0, 4'b0000, 1'b0, 32'h10, 32'h0);
    idle(2);
    chk("t1_rdata", rdata_a, 32'hDEAD_BEEF);

    // byte lanes
    xact(1'b0, 4'b1010, 1'b1, 32'h20, 32'hAABB_CCDD);
    xact(1'b0, 4'b1111 ^ 4'b1111, 1'b0, 32'h20, 32'h0);
    idle(2);
    chk("t2_rdata", rdata_a, 32'h11BB_33DD);

    // waited write with bus scrambled during wait, then read
    xact(1'b1, 4'b0000, 1'b1, 32'h18, 32'h1357_9BDF);
    xact(1'b1, 4'b0000, 1'b0, 32'h18, 32'h0);
    idle(6);
    chk("t3_rdata", rdata_b, 32'h1357_9BDF);

    // back-to-back reads and a write overlapping rrdy
    xact(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    xact(1'b1, 4'b0110, 1'b0, 32'h4, 32'h0);
    xact(1'b1, 4'b0000, 1'b1, 32'h8, 32'hCAFE_F00D);
    xact(1'b1, 4'b0000, 1'b0, 32'h8, 32'h0);
    idle(6);
    chk("t4_rdata", rdata_b, 32'hCAFE_F00D);

    // aliasing of high and low address bits
    xact(1'b0, 4'b0000, 1'b1, 32'h1000, 32'hC0FF_EE01);
    xact(1'b0, 4'b0000, 1'b0, 32'h3, 32'h0);
    idle(2);
    chk("t6_rdata", rdata_a, 32'hC0FF_EE01);
    idle(10);

    // reset in the middle of a waited write
    @(posedge clk); #1;
    drive(1'b1, 4'b0000, 1'b1, 32'h30, 32'h5A5A_5A5A);
    k0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_wait", cyc - k0, 32'd2);
    chk("t5_busy", {31'd0, busy_b}, 32'd1);
    reset = 1'b1;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    #1;
    chk("t5_rst_busy", {31'd0, busy_b}, 32'd0);
    chk("t5_rst_ack", {31'd0, ack_b}, 32'd0);
    drive(1'b1, 4'hF, 1'b0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    xact(1'b1, 4'b0000, 1'b0, 32'h30, 32'h0);
    idle(6);
    chk("t5_rdata", rdata_b, 32'h0);

    // reset drops a read already in the pipe
    xact(1'b1, 4'b0000, 1'b0, 32'h10, 32'h0);
    do_reset();
    idle(8);

    for (int k = 0; k < 80; k++) begin
      bit          s;
      logic        w;
      logic [3:0]  c;
      logic [3:0]  idx;
      logic [31:0] a;
      s   = 1'($urandom);
      w   = 1'($urandom);
      c   = 4'($urandom_range(0, 14));
      idx = 4'($urandom);
      a   = ($urandom & 32'hFFFF_F003) | {26'd0, idx, 2'b00};
      xact(s, c, w, a, $urandom);
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 3));
    end
    idle(8);

    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
